// File: rtl/xtea_pkg.sv
// Shared types, constants and the XTEA mixing function for the round engine.
package xtea_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] block_t;

  localparam word_t       XTEA_DELTA          = 32'h9E3779B9;
  localparam int unsigned XTEA_ROUNDS_DEFAULT = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // F(x) = ((x << 4) ^ (x >> 5)) + x, mod 2^32
  function automatic word_t xtea_mix(input word_t x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

endpackage

// File: rtl/xtea_round_engine_if.sv
// Block/key input and result output handshake bundle for the XTEA round engine.
interface xtea_round_engine_if;
  import xtea_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [127:0] key_in;
  block_t       data_in;
  logic         out_valid;
  logic         out_ready;
  block_t       data_out;

  modport master (
    output in_valid, mode, key_in, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, mode, key_in, data_in, out_ready,
    output in_ready, out_valid, data_out
  );

endinterface

// File: rtl/xtea_round_engine_key_sel.sv
// Key-segment selector: picks k[sum & 3] (y_z_switch=0) or k[(sum >> 11) & 3] (y_z_switch=1).
module xtea_round_engine_key_sel
  import xtea_pkg::*;
(
  input  logic [127:0] key,
  input  word_t        sum,
  input  logic         y_z_switch,
  output word_t        key_segment
);

  logic [1:0] idx_c;

  assign idx_c       = y_z_switch ? 2'((sum >> 11) & 32'd3) : 2'(sum & 32'd3);
  assign key_segment = key[{idx_c, 5'd0} +: 32];

endmodule

// File: rtl/xtea_round_engine.sv
// Iterative XTEA encrypt/decrypt engine, one half-round per clock by default.
// Define XTEA_FULL_ROUND_EN to compute a full round (both halves) per clock.
module xtea_round_engine
  import xtea_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = XTEA_ROUNDS_DEFAULT,
  parameter word_t       DELTA      = XTEA_DELTA
) (
  input  logic                clk,
  input  logic                rst_n,
  xtea_round_engine_if.slave  bus
);

  localparam int unsigned      CNT_W        = 7;
  localparam word_t            SUM_DEC_INIT = 32'(64'(DELTA) * 64'(NUM_ROUNDS));
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(NUM_ROUNDS - 1);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  block_t           data_out_q, data_out_d;
  word_t            v0_q, v0_d;
  word_t            v1_q, v1_d;
  word_t            sum_q, sum_d;
  logic [127:0]     key_q, key_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Datapath results for the current RUN cycle
  word_t v0_h_c, v1_h_c, sum_h_c;
  logic  last_c;

`ifdef XTEA_FULL_ROUND_EN
  word_t sum1_c;
  word_t sel0_sum_c, sel1_sum_c;
  word_t kseg0_c, kseg1_c;

  // Second half uses the sum after this round's DELTA step in either direction
  assign sum1_c     = mode_q ? (sum_q - DELTA) : (sum_q + DELTA);
  assign sel0_sum_c = mode_q ? sum1_c : sum_q;
  assign sel1_sum_c = mode_q ? sum_q  : sum1_c;

  xtea_round_engine_key_sel u_key_sel_y (
    .key         (key_q),
    .sum         (sel0_sum_c),
    .y_z_switch  (1'b0),
    .key_segment (kseg0_c)
  );

  xtea_round_engine_key_sel u_key_sel_z (
    .key         (key_q),
    .sum         (sel1_sum_c),
    .y_z_switch  (1'b1),
    .key_segment (kseg1_c)
  );

  always_comb begin
    v0_h_c  = v0_q;
    v1_h_c  = v1_q;
    sum_h_c = sum1_c;
    if (!mode_q) begin
      v0_h_c = v0_q + (xtea_mix(v1_q) ^ (sel0_sum_c + kseg0_c));
      v1_h_c = v1_q + (xtea_mix(v0_h_c) ^ (sel1_sum_c + kseg1_c));
    end else begin
      v1_h_c = v1_q - (xtea_mix(v0_q) ^ (sel1_sum_c + kseg1_c));
      v0_h_c = v0_q - (xtea_mix(v1_h_c) ^ (sel0_sum_c + kseg0_c));
    end
  end

  assign last_c = (cnt_q == LAST_CNT);
`else
  logic  half_q, half_d;
  logic  yz_c;
  word_t kseg_c;
  word_t f_c;

  // Encrypt half 0 and decrypt half 1 work on v0 (selector 0); the others on v1
  assign yz_c = mode_q ^ half_q;

  xtea_round_engine_key_sel u_key_sel (
    .key         (key_q),
    .sum         (sum_q),
    .y_z_switch  (yz_c),
    .key_segment (kseg_c)
  );

  assign f_c = xtea_mix(yz_c ? v0_q : v1_q) ^ (sum_q + kseg_c);

  always_comb begin
    v0_h_c  = v0_q;
    v1_h_c  = v1_q;
    sum_h_c = sum_q;
    case ({mode_q, half_q})
      2'b00: begin
        v0_h_c  = v0_q + f_c;
        sum_h_c = sum_q + DELTA;
      end
      2'b01: v1_h_c = v1_q + f_c;
      2'b10: begin
        v1_h_c  = v1_q - f_c;
        sum_h_c = sum_q - DELTA;
      end
      default: v0_h_c = v0_q - f_c;
    endcase
  end

  assign last_c = half_q && (cnt_q == LAST_CNT);
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    sum_d       = sum_q;
    key_d       = key_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
`ifndef XTEA_FULL_ROUND_EN
    half_d      = half_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          key_d   = bus.key_in;
          mode_d  = bus.mode;
          v0_d    = bus.data_in[63:32];
          v1_d    = bus.data_in[31:0];
          sum_d   = bus.mode ? SUM_DEC_INIT : '0;
          cnt_d   = '0;
`ifndef XTEA_FULL_ROUND_EN
          half_d  = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        v0_d  = v0_h_c;
        v1_d  = v1_h_c;
        sum_d = sum_h_c;
`ifdef XTEA_FULL_ROUND_EN
        cnt_d = cnt_q + CNT_W'(1);
`else
        half_d = ~half_q;
        if (half_q) cnt_d = cnt_q + CNT_W'(1);
`endif
        if (last_c) begin
          data_out_d  = {v0_h_c, v1_h_c};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
`ifndef XTEA_FULL_ROUND_EN
      half_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
`ifndef XTEA_FULL_ROUND_EN
      half_q      <= half_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;

endmodule
